// File: rtl/mem_access_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_responder
// Purpose  : Fixed-latency line read/write responder behind the memory-port
//            arbiter. Optional macro MEM_GRANT_CHECK_EN rejects multi-hot grants.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_responder #(
    parameter int ADDR_W  = 6,
    parameter int LINE_W  = 128,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              v_m_download_m,
    input  logic              v_d_m_areg_m,
    input  logic              v_i_m_areg_m,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              mem_access_done,
    output logic [LINE_W-1:0] rd_data,
    output logic [1:0]        rd_src,
    output logic              busy,
    output logic              grant_err
);

    localparam int c_depth = 2 ** ADDR_W;
    localparam int c_cnt_w = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              r_state_q,   w_state_d;
    logic [c_cnt_w-1:0]  r_cnt_q,     w_cnt_d;
    logic [ADDR_W-1:0]   r_addr_q,    w_addr_d;
    logic                r_wr_q,      w_wr_d;
    logic [LINE_W-1:0]   r_wdata_q,   w_wdata_d;
    logic [1:0]          r_src_q,     w_src_d;
    logic                r_done_q,    w_done_d;
    logic                r_busy_q,    w_busy_d;
    logic                r_err_q,     w_err_d;
    logic [LINE_W-1:0]   r_rd_data_q, w_rd_data_d;
    logic [1:0]          r_rd_src_q,  w_rd_src_d;
    logic                w_mem_we;
    logic                w_accept;
    logic                w_multi_err;
    logic [1:0]          w_grant_src;

    logic [LINE_W-1:0]   r_mem [c_depth];

    // Fixed priority download > dcache > icache; unique when single-hot.
    assign w_grant_src = v_m_download_m ? 2'b01 :
                         v_d_m_areg_m   ? 2'b10 : 2'b11;

`ifdef MEM_GRANT_CHECK_EN
    logic w_multi;
    assign w_multi     = (32'(v_m_download_m) + 32'(v_d_m_areg_m) + 32'(v_i_m_areg_m)) > 32'd1;
    assign w_accept    = (v_m_download_m | v_d_m_areg_m | v_i_m_areg_m) & ~w_multi;
    assign w_multi_err = w_multi;
`else
    assign w_accept    = v_m_download_m | v_d_m_areg_m | v_i_m_areg_m;
    assign w_multi_err = 1'b0;
`endif

    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_addr_d    = r_addr_q;
        w_wr_d      = r_wr_q;
        w_wdata_d   = r_wdata_q;
        w_src_d     = r_src_q;
        w_done_d    = 1'b0;
        w_err_d     = 1'b0;
        w_rd_data_d = r_rd_data_q;
        w_rd_src_d  = r_rd_src_q;
        w_mem_we    = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                w_err_d = w_multi_err;
                if (w_accept) begin
                    w_addr_d  = req_addr;
                    w_wr_d    = req_wr;
                    w_wdata_d = req_wdata;
                    w_src_d   = w_grant_src;
                    w_cnt_d   = c_cnt_load;
                    w_state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_cnt_q != '0) begin
                    w_cnt_d = r_cnt_q - 1'b1;
                end else begin
                    if (r_wr_q) begin
                        w_mem_we = 1'b1;
                    end else begin
                        w_rd_data_d = r_mem[r_addr_q];
                    end
                    w_rd_src_d = r_src_q;
                    w_done_d   = 1'b1;
                    w_state_d  = S_DONE;
                end
            end
            S_DONE:  w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
        w_busy_d = (w_state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q   <= S_IDLE;
            r_cnt_q     <= '0;
            r_addr_q    <= '0;
            r_wr_q      <= 1'b0;
            r_wdata_q   <= '0;
            r_src_q     <= '0;
            r_done_q    <= 1'b0;
            r_busy_q    <= 1'b0;
            r_err_q     <= 1'b0;
            r_rd_data_q <= '0;
            r_rd_src_q  <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_addr_q    <= w_addr_d;
            r_wr_q      <= w_wr_d;
            r_wdata_q   <= w_wdata_d;
            r_src_q     <= w_src_d;
            r_done_q    <= w_done_d;
            r_busy_q    <= w_busy_d;
            r_err_q     <= w_err_d;
            r_rd_data_q <= w_rd_data_d;
            r_rd_src_q  <= w_rd_src_d;
        end
    end

    // Line storage is deliberately not reset; a reset aborts the write
    // because it clears the state that gates w_mem_we.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr_q] <= r_wdata_q;
        end
    end

    assign mem_access_done = r_done_q;
    assign rd_data         = r_rd_data_q;
    assign rd_src          = r_rd_src_q;
    assign busy            = r_busy_q;
    assign grant_err       = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_responder
// Purpose  : Directed self-checking bench for mem_access_responder (LATENCY=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         g_dl = 1'b0, g_dc = 1'b0, g_ic = 1'b0;
    logic [5:0]   req_addr = '0;
    logic         req_wr = 1'b0;
    logic [127:0] req_wdata = '0;
    logic         done;
    logic [127:0] rd_data;
    logic [1:0]   rd_src;
    logic         busy;
    logic         grant_err;

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] c_l5   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] c_a5   = {32{4'hA, 4'h5}};
    localparam logic [127:0] c_l1   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] c_junk = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

    mem_access_responder #(.ADDR_W(6), .LINE_W(128), .LATENCY(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .v_m_download_m  (g_dl),
        .v_d_m_areg_m    (g_dc),
        .v_i_m_areg_m    (g_ic),
        .req_addr        (req_addr),
        .req_wr          (req_wr),
        .req_wdata       (req_wdata),
        .mem_access_done (done),
        .rd_data         (rd_data),
        .rd_src          (rd_src),
        .busy            (busy),
        .grant_err       (grant_err)
    );

    always #5 clk = ~clk;

    // Present a request for one edge; returns 1ns after the capture edge.
    task automatic issue(input logic [2:0] g, input logic [5:0] a,
                         input logic wr, input logic [127:0] d);
        {g_ic, g_dc, g_dl} = g;
        req_addr  = a;
        req_wr    = wr;
        req_wdata = d;
        @(posedge clk); #1;
        {g_ic, g_dc, g_dl} = 3'b000;
    endtask

    // Cycles from capture edge to the edge after which done is seen (99 = timeout).
    task automatic wait_done(output int cyc);
        cyc = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic gap();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({done, busy, grant_err, rd_src, rd_data} !== '0) begin
            $display("FAIL reset_outputs: got done=%b busy=%b err=%b src=%b data=%h, want all 0",
                     done, busy, grant_err, rd_src, rd_data);
            fails++;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        gap();
    endtask

    task automatic test_read();
        int cyc, bc;
        issue(3'b010, 6'd5, 1'b1, c_l5);
        wait_done(cyc);
        tests++;
        if (rd_data !== 128'h0 || rd_src !== 2'b10) begin
            $display("FAIL preload_write: got data=%h src=%b, want data=0 src=10", rd_data, rd_src);
            fails++;
        end
        gap();
        issue(3'b010, 6'd5, 1'b0, c_junk);
        cyc = 99;
        bc  = busy ? 1 : 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (busy) bc++;
            if (done) begin
                cyc = i;
                break;
            end
        end
        tests++;
        if (cyc != 4) begin
            $display("FAIL read_latency: got %0d cycles, want 4", cyc);
            fails++;
        end
        tests++;
        if (rd_data !== c_l5 || rd_src !== 2'b10) begin
            $display("FAIL read_data: got data=%h src=%b, want data=%h src=10", rd_data, rd_src, c_l5);
            fails++;
        end
        tests++;
        if (bc != 5) begin
            $display("FAIL busy_window: got %0d busy cycles, want 5", bc);
            fails++;
        end
        gap();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL done_width: got done=%b busy=%b, want 0 0", done, busy);
            fails++;
        end
    endtask

    task automatic test_write_then_read();
        int cyc;
        issue(3'b001, 6'd3, 1'b1, c_a5);
        wait_done(cyc);
        tests++;
        if (cyc != 4 || rd_data !== c_l5 || rd_src !== 2'b01) begin
            $display("FAIL write_keeps_rd_data: got cyc=%0d data=%h src=%b, want 4 %h 01",
                     cyc, rd_data, rd_src, c_l5);
            fails++;
        end
        gap();
        issue(3'b100, 6'd3, 1'b0, '0);
        wait_done(cyc);
        tests++;
        if (cyc != 4 || rd_data !== c_a5 || rd_src !== 2'b11) begin
            $display("FAIL read_back: got cyc=%0d data=%h src=%b, want 4 %h 11",
                     cyc, rd_data, rd_src, c_a5);
            fails++;
        end
        gap();
    endtask

    task automatic test_priority();
        int cyc;
        issue(3'b100, 6'd1, 1'b1, c_l1);
        wait_done(cyc);
        gap();
        issue(3'b111, 6'd1, 1'b0, '0);
`ifdef MEM_GRANT_CHECK_EN
        tests++;
        if (grant_err !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL multi_hot_reject: got err=%b busy=%b, want 1 0", grant_err, busy);
            fails++;
        end
        gap();
        tests++;
        if (grant_err !== 1'b0) begin
            $display("FAIL grant_err_width: got err=%b, want 0", grant_err);
            fails++;
        end
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) cyc++;
            gap();
        end
        tests++;
        if (cyc != 0) begin
            $display("FAIL multi_hot_no_access: got %0d active cycles, want 0", cyc);
            fails++;
        end
`else
        tests++;
        if (grant_err !== 1'b0) begin
            $display("FAIL grant_err_tied: got err=%b, want 0", grant_err);
            fails++;
        end
        wait_done(cyc);
        tests++;
        if (cyc != 4 || rd_src !== 2'b01 || rd_data !== c_l1) begin
            $display("FAIL priority_download: got cyc=%0d src=%b data=%h, want 4 01 %h",
                     cyc, rd_src, rd_data, c_l1);
            fails++;
        end
        gap();
`endif
    endtask

    task automatic test_back_to_back();
        int last, npulse, bad;
        g_dc = 1'b1; req_addr = 6'd5; req_wr = 1'b0;
        last = -1; npulse = 0; bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                if (last >= 0 && (i - last) != 6) bad++;
                last = i;
                npulse++;
            end
        end
        g_dc = 1'b0;
        tests++;
        if (npulse < 6 || bad != 0) begin
            $display("FAIL back_to_back: got %0d pulses %0d bad spacings, want >=6 and 0",
                     npulse, bad);
            fails++;
        end
        for (int i = 0; i < 20; i++) begin
            if (!busy && !done) break;
            gap();
        end
        tests++;
        if (busy !== 1'b0 || rd_data !== c_l5 || rd_src !== 2'b10) begin
            $display("FAIL back_to_back_drain: got busy=%b data=%h src=%b, want 0 %h 10",
                     busy, rd_data, rd_src, c_l5);
            fails++;
        end
        gap();
    endtask

    task automatic test_change_during_access();
        int cyc;
        issue(3'b010, 6'd5, 1'b0, '0);
        g_ic = 1'b1; req_addr = 6'd3; req_wr = 1'b1; req_wdata = c_junk;
        gap();
        gap();
        g_ic = 1'b0; req_wr = 1'b0;
        wait_done(cyc);
        cyc = cyc + 2;
        tests++;
        if (cyc != 4 || rd_data !== c_l5 || rd_src !== 2'b10) begin
            $display("FAIL captured_request: got cyc=%0d data=%h src=%b, want 4 %h 10",
                     cyc, rd_data, rd_src, c_l5);
            fails++;
        end
        gap();
        issue(3'b001, 6'd3, 1'b0, '0);
        wait_done(cyc);
        tests++;
        if (rd_data !== c_a5 || rd_src !== 2'b01) begin
            $display("FAIL ignored_write: got data=%h src=%b, want %h 01", rd_data, rd_src, c_a5);
            fails++;
        end
        gap();
    endtask

    task automatic test_reset_mid_access();
        int cyc, seen;
        issue(3'b001, 6'd5, 1'b1, c_junk);
        gap();
        rst = 1'b1;
        #1;
        tests++;
        if ({done, busy, grant_err, rd_src, rd_data} !== '0) begin
            $display("FAIL reset_mid_outputs: got done=%b busy=%b err=%b src=%b data=%h, want all 0",
                     done, busy, grant_err, rd_src, rd_data);
            fails++;
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) seen++;
            gap();
        end
        tests++;
        if (seen != 0) begin
            $display("FAIL reset_abort: got %0d active cycles after reset, want 0", seen);
            fails++;
        end
        issue(3'b010, 6'd5, 1'b0, '0);
        wait_done(cyc);
        tests++;
        if (cyc != 4 || rd_data !== c_l5) begin
            $display("FAIL reset_no_write: got cyc=%0d data=%h, want 4 %h", cyc, rd_data, c_l5);
            fails++;
        end
        gap();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_then_read();
        test_priority();
        test_back_to_back();
        test_change_during_access();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
